// File: rtl/ro_freq_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter:
// FSM state encoding and the default sizing constants.
package ro_pkg;

    localparam int CNT_W_DEF  = 24;
    localparam int WIN_W_DEF  = 16;
    localparam int SETTLE_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/ro_freq_meter_if.sv
// Control/result bundle between a measurement requester (master)
// and the frequency meter (slave).
interface ro_freq_meter_if
    import ro_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
);
    logic             start;
    logic             abort;
    logic [WIN_W-1:0] window_cycles;
    logic             ro_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output start, abort, window_cycles,
        input  ro_en, busy, done, count, overflow
    );

    modport slave (
        input  start, abort, window_cycles,
        output ro_en, busy, done, count, overflow
    );
endinterface

// File: rtl/ro_freq_meter_sync.sv
// Two-flop synchronizer bringing the free-running oscillator output
// into the clk domain. Both flops are kept so that tools do not merge
// or retime them away.
module ro_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    (* keep = "true" *) logic meta;
    (* keep = "true" *) logic sync;

    // First flop may go metastable; second gives it a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;
endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, lets it settle
// for SETTLE cycles, then counts synchronized rising edges of ro_q over a
// window of window_cycles clk cycles and publishes the result.
// Build option: define RO_FREQ_METER_SAT_EN to saturate the edge counter
// at full scale; otherwise it wraps. Either way overflow sticks for the window.
module ro_freq_meter
    import ro_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WIN_W  = WIN_W_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_q,
    ro_freq_meter_if.slave   bus
);
    logic             sync_q;
    logic             prev_q;
    logic             edge_hit;

    state_t           state, state_nxt;
    logic [WIN_W-1:0] timer, timer_nxt;
    logic [WIN_W-1:0] win_lat, win_lat_nxt;
    logic [CNT_W-1:0] work, work_nxt, work_inc;
    logic             work_ovf, work_ovf_nxt, inc_ovf;
    logic [CNT_W-1:0] count_nxt;
    logic             ovf_nxt;
    logic             ro_en_nxt, busy_nxt, done_nxt;

    ro_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ro_q),
        .q     (sync_q)
    );

    // Remember the previous synchronized level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= sync_q;
    end

    assign edge_hit = sync_q & ~prev_q;

`ifdef RO_FREQ_METER_SAT_EN
    // Saturating increment: an edge arriving at full scale only flags overflow.
    always_comb begin
        work_inc = work;
        inc_ovf  = 1'b0;
        if (edge_hit) begin
            if (&work) inc_ovf  = 1'b1;
            else       work_inc = work + 1'b1;
        end
    end
`else
    // Wrapping increment: rolling over from full scale flags overflow.
    always_comb begin
        work_inc = work;
        inc_ovf  = 1'b0;
        if (edge_hit) begin
            work_inc = work + 1'b1;
            inc_ovf  = &work;
        end
    end
`endif

    // Next-state and datapath decisions; abort beats everything while busy.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        win_lat_nxt  = win_lat;
        work_nxt     = work;
        work_ovf_nxt = work_ovf;
        count_nxt    = bus.count;
        ovf_nxt      = bus.overflow;
        done_nxt     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_nxt    = ST_SETTLE;
                    win_lat_nxt  = bus.window_cycles;
                    timer_nxt    = WIN_W'(SETTLE - 1);
                    work_nxt     = '0;
                    work_ovf_nxt = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                end else if (timer == '0) begin
                    if (win_lat == '0) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        count_nxt = work;
                        ovf_nxt   = work_ovf;
                    end else begin
                        state_nxt = ST_MEASURE;
                        timer_nxt = win_lat - 1'b1;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            ST_MEASURE: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    work_nxt     = work_inc;
                    work_ovf_nxt = work_ovf | inc_ovf;
                    if (timer == '0) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        count_nxt = work_inc;
                        ovf_nxt   = work_ovf | inc_ovf;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        ro_en_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_MEASURE);
        busy_nxt  = ro_en_nxt;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer        <= '0;
            win_lat      <= '0;
            work         <= '0;
            work_ovf     <= 1'b0;
            bus.count    <= '0;
            bus.overflow <= 1'b0;
            bus.ro_en    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            timer        <= timer_nxt;
            win_lat      <= win_lat_nxt;
            work         <= work_nxt;
            work_ovf     <= work_ovf_nxt;
            bus.count    <= count_nxt;
            bus.overflow <= ovf_nxt;
            bus.ro_en    <= ro_en_nxt;
            bus.busy     <= busy_nxt;
            bus.done     <= done_nxt;
        end
    end
endmodule
